// File: rtl/d2l_master.sv
// Dual Data Link transmitter: serialises a word two bits per sclk cycle, MSB pair first,
// framed by active-low CS. All outputs are registered on posedge sclk.
module d2l_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  OutLine0,
    output logic                  OutLine1,
    output logic                  CS,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned NumPairs    = DATA_WIDTH / 2;
    localparam int unsigned RecoverLoad = NumPairs + 3;
    localparam int unsigned GapLoad     = GAP_CYCLES - 2;
    localparam int unsigned CntMax      = (RecoverLoad > GapLoad) ? RecoverLoad : GapLoad;
    localparam int unsigned CntW        = $clog2(CntMax + 1);
    localparam int unsigned PairW       = (NumPairs > 1) ? $clog2(NumPairs) : 1;

    if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 2 || DATA_WIDTH > 126) begin : g_bad_width
        $error("d2l_master: DATA_WIDTH must be even and within 2..126");
    end
    if (GAP_CYCLES < 2) begin : g_bad_gap
        $error("d2l_master: GAP_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        StRecover,
        StIdle,
        StStart,
        StData,
        StGap
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [PairW-1:0]        pair_q, pair_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    cs_q, cs_d;
    logic                    line1_q, line1_d;
    logic                    line0_q, line0_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        shift_d = shift_q;
        cs_d    = 1'b1;
        line1_d = 1'b0;
        line0_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            // Lets a slave cut off mid-frame run out its frame before the next CS-low.
            StRecover: begin
                if (cnt_q > CntW'(1)) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (tx_valid) begin
                    shift_d = tx_data;
                    pair_d  = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                cs_d               = 1'b0;
                busy_d             = 1'b1;
                {line1_d, line0_d} = shift_q[DATA_WIDTH-1 -: 2];
                shift_d            = shift_q << 2;
                state_d            = StData;
            end
            StData: begin
                if (pair_q == PairW'(NumPairs - 1)) begin
                    done_d  = 1'b1;
                    cnt_d   = CntW'(GapLoad);
                    state_d = StGap;
                end else begin
                    cs_d               = 1'b0;
                    busy_d             = 1'b1;
                    {line1_d, line0_d} = shift_q[DATA_WIDTH-1 -: 2];
                    shift_d            = shift_q << 2;
                    pair_d             = pair_q + PairW'(1);
                end
            end
            // IDLE itself is the last gap cycle, so GAP lasts GAP_CYCLES-1 cycles.
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                cnt_d   = CntW'(RecoverLoad);
                state_d = StRecover;
            end
        endcase

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= StRecover;
            cnt_q   <= CntW'(RecoverLoad);
            pair_q  <= '0;
            shift_q <= '0;
            cs_q    <= 1'b1;
            line1_q <= 1'b0;
            line0_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
            shift_q <= shift_d;
            cs_q    <= cs_d;
            line1_q <= line1_d;
            line0_q <= line0_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready   = ready_q;
    assign OutLine0   = line0_q;
    assign OutLine1   = line1_q;
    assign CS         = cs_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_d2l_master.sv
// Bench for d2l_master: a negedge-sampling slave model decodes frames from two instances
// (8-bit/gap 2 and 16-bit/gap 3) and checks them against a queue of accepted words.
module tb_d2l_master;

    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic        rst0, valid0, ready0, l0_0, l1_0, cs0, busy0, fd0;
    logic [7:0]  data0;
    logic        rst1, valid1, ready1, l0_1, l1_1, cs1, busy1, fd1;
    logic [15:0] data1;

    d2l_master #(.DATA_WIDTH(8), .GAP_CYCLES(2)) u_dut0 (
        .sclk(sclk), .rst(rst0), .tx_data(data0), .tx_valid(valid0), .tx_ready(ready0),
        .OutLine0(l0_0), .OutLine1(l1_0), .CS(cs0), .busy(busy0), .frame_done(fd0)
    );

    d2l_master #(.DATA_WIDTH(16), .GAP_CYCLES(3)) u_dut1 (
        .sclk(sclk), .rst(rst1), .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
        .OutLine0(l0_1), .OutLine1(l1_1), .CS(cs1), .busy(busy1), .frame_done(fd1)
    );

    int n_checks = 0;
    int n_errs   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int pairs_of(input int id);
        return (id == 0) ? 4 : 8;
    endfunction

    function automatic int gap_of(input int id);
        return (id == 0) ? 2 : 3;
    endfunction

    // Scoreboard: words the bench handed over, in send order.
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    // Slave model state per instance.
    bit          in_frame[2]    = '{0, 0};
    bit          after_frame[2] = '{0, 0};
    bit          abort_flag[2]  = '{0, 0};
    int          fcnt[2]        = '{0, 0};
    int          gap_run[2]     = '{1000, 1000};
    int          last_gap[2]    = '{0, 0};
    int          fall_cyc[2]    = '{0, 0};
    int          prev_fall[2]   = '{0, 0};
    logic [15:0] acc[2];
    int          cyc = 0;

    task automatic mon_step(input int id, input logic cs, input logic l1, input logic l0,
                            input logic fd, input logic bz, input logic rdy);
        logic [15:0] exp_w;
        int          qs;
        check($sformatf("busy%0d", id), 32'(bz), 32'(!cs));
        if (cs == 1'b0) begin
            check($sformatf("ready_in_frame%0d", id), 32'(rdy), 32'd0);
            check($sformatf("done_in_frame%0d", id), 32'(fd), 32'd0);
            if (!in_frame[id]) begin
                in_frame[id] = 1'b1;
                fcnt[id]     = 0;
                acc[id]      = '0;
                check($sformatf("start_lines%0d", id), 32'({l1, l0}), 32'd0);
                if (after_frame[id])
                    check($sformatf("gap_min%0d", id), 32'(gap_run[id] >= gap_of(id)), 32'd1);
                last_gap[id]  = gap_run[id];
                prev_fall[id] = fall_cyc[id];
                fall_cyc[id]  = cyc;
            end else begin
                fcnt[id]++;
                acc[id] = {acc[id][13:0], l1, l0};
                if (fcnt[id] > pairs_of(id))
                    check($sformatf("cs_low_len%0d", id), fcnt[id], pairs_of(id));
            end
        end else begin
            check($sformatf("idle_lines%0d", id), 32'({l1, l0}), 32'd0);
            if (in_frame[id]) begin
                in_frame[id] = 1'b0;
                gap_run[id]  = 1;
                check($sformatf("ready_at_end%0d", id), 32'(rdy), 32'd0);
                if (abort_flag[id]) begin
                    check($sformatf("abort_no_done%0d", id), 32'(fd), 32'd0);
                    abort_flag[id]  = 1'b0;
                    after_frame[id] = 1'b0;
                end else begin
                    check($sformatf("frame_done%0d", id), 32'(fd), 32'd1);
                    check($sformatf("cs_low_len%0d", id), fcnt[id], pairs_of(id));
                    qs = (id == 0) ? q0.size() : q1.size();
                    check($sformatf("frame_expected%0d", id), 32'(qs > 0), 32'd1);
                    if (qs > 0) begin
                        if (id == 0) exp_w = q0.pop_front();
                        else         exp_w = q1.pop_front();
                        check($sformatf("word%0d", id), 32'(acc[id]), 32'(exp_w));
                    end
                    after_frame[id] = 1'b1;
                end
            end else begin
                gap_run[id]++;
                check($sformatf("done_outside%0d", id), 32'(fd), 32'd0);
                if (after_frame[id] && gap_run[id] < gap_of(id))
                    check($sformatf("ready_in_gap%0d", id), 32'(rdy), 32'd0);
                if (after_frame[id] && gap_run[id] == gap_of(id))
                    check($sformatf("ready_after_gap%0d", id), 32'(rdy), 32'd1);
            end
        end
    endtask

    always @(negedge sclk) begin
        cyc++;
        mon_step(0, cs0, l1_0, l0_0, fd0, busy0, ready0);
        mon_step(1, cs1, l1_1, l0_1, fd1, busy1, ready1);
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input int id, input logic [15:0] w, input bit hold, input bit push);
        int k;
        if (id == 0) begin data0 = w[7:0]; valid0 = 1'b1; end
        else         begin data1 = w;      valid1 = 1'b1; end
        for (k = 0; k < 100; k++) begin
            if (((id == 0) ? ready0 : ready1) == 1'b1) break;
            @(negedge sclk);
        end
        check("send_accept", 32'(k < 100), 32'd1);
        if (push) begin
            if (id == 0) q0.push_back(w & 16'h00FF);
            else         q1.push_back(w);
        end
        @(negedge sclk);
        if (!hold) begin
            if (id == 0) valid0 = 1'b0;
            else         valid1 = 1'b0;
        end
    endtask

    task automatic wait_ready(input int id);
        for (int k = 0; k < 200; k++) begin
            if (((id == 0) ? ready0 : ready1) == 1'b1) break;
            @(negedge sclk);
        end
        check("wait_ready", 32'((id == 0) ? ready0 : ready1), 32'd1);
    endtask

    task automatic recover_check0();
        check("recover_ready", 32'(ready0), 32'd0);
        repeat (6) begin
            @(negedge sclk);
            check("recover_ready", 32'(ready0), 32'd0);
        end
        @(negedge sclk);
        check("recover_done", 32'(ready0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        bit          hold;
        rst0 = 1'b1; rst1 = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        data0 = '0; data1 = '0;

        repeat (3) begin
            @(negedge sclk);
            check("rst_cs", 32'(cs0), 32'd1);
            check("rst_lines", 32'({l1_0, l0_0}), 32'd0);
            check("rst_ready", 32'(ready0), 32'd0);
            check("rst_busy", 32'(busy0), 32'd0);
            check("rst_done", 32'(fd0), 32'd0);
        end
        rst0 = 1'b0; rst1 = 1'b0;
        recover_check0();

        send(0, 16'h00B4, 1'b0, 1'b1);
        wait_ready(0);

        send(0, 16'h00A5, 1'b1, 1'b1);
        send(0, 16'h003C, 1'b0, 1'b1);
        repeat (2) @(negedge sclk);
        check("b2b_gap", last_gap[0], 2);
        check("b2b_period", fall_cyc[0] - prev_fall[0], 7);
        wait_ready(0);

        send(0, 16'h000F, 1'b0, 1'b1);
        repeat (2) @(negedge sclk);
        data0 = 8'hFF; valid0 = 1'b1;
        check("busy_ready", 32'(ready0), 32'd0);
        @(negedge sclk);
        valid0 = 1'b0;
        wait_ready(0);

        send(0, 16'h00C3, 1'b0, 1'b0);
        repeat (2) @(negedge sclk);
        abort_flag[0] = 1'b1;
        rst0 = 1'b1;
        @(negedge sclk);
        rst0 = 1'b0;
        check("abort_cs", 32'(cs0), 32'd1);
        check("abort_lines", 32'({l1_0, l0_0}), 32'd0);
        check("abort_done", 32'(fd0), 32'd0);
        recover_check0();
        send(0, 16'h005A, 1'b0, 1'b1);
        wait_ready(0);

        wait_ready(1);
        send(1, 16'h1234, 1'b1, 1'b1);
        send(1, 16'hABCD, 1'b0, 1'b1);
        repeat (2) @(negedge sclk);
        check("sweep_gap", last_gap[1], 3);
        check("sweep_period", fall_cyc[1] - prev_fall[1], 12);
        wait_ready(1);

        for (int i = 0; i < 25; i++) begin
            w    = 16'($urandom);
            hold = (i < 24) ? bit'($urandom_range(0, 1)) : 1'b0;
            send(0, w, hold, 1'b1);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge sclk);
        end
        for (int i = 0; i < 8; i++) begin
            w    = 16'($urandom);
            hold = (i < 7) ? bit'($urandom_range(0, 1)) : 1'b0;
            send(1, w, hold, 1'b1);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge sclk);
        end
        wait_ready(0);
        wait_ready(1);
        repeat (5) @(negedge sclk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/d2l_master.md
Name: d2l_master

Overview:
- Transmit end of the Dual Data Link (D2L): serialises a parallel word onto two data lines, 2 bits per sclk cycle, MSB pair first, framed by active-low CS.
- Drives the existing D2L slave, which samples on negedge sclk. This block updates all outputs on posedge sclk, giving half a period of setup and hold at the slave.
- Accepts words from local logic through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8: word width. Must be even and in the range 2..126 (the slave counts pairs in 6 bits).
- GAP_CYCLES, 2: minimum whole sclk cycles CS is held high between frames. Must be >= 2, because the slave spends 2 negedges in END_RX/IDLE re-entry before it samples CS again.

Ports:
- sclk  in  1  link clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- tx_data  in  DATA_WIDTH  word to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  block can accept a word this cycle
- OutLine0  out  1  data line 0 (lower bit of each pair)
- OutLine1  out  1  data line 1 (upper bit of each pair)
- CS  out  1  slave select, active low
- busy  out  1  frame in progress (START or DATA)
- frame_done  out  1  one-cycle pulse after the last pair is driven

Behaviour:
- Reset and synchronicity: one clock (sclk); reset is synchronous and active-high. All outputs are registered.
- Reset values: CS=1, OutLine0=OutLine1=0, tx_ready=0, busy=0, frame_done=0. State=RECOVER, recovery counter loaded with DATA_WIDTH/2+3.
- States: RECOVER, IDLE, START, DATA, GAP.
- RECOVER:
  - CS=1, lines=0, tx_ready=0.
  - Counts down to 0, then goes to IDLE.
  - Purpose: a slave interrupted mid-frame runs out its frame and returns to IDLE before a new CS-low.
- IDLE:
  - tx_ready=1, CS=1, lines=0.
  - On a posedge with tx_valid=1 the word is accepted: tx_data goes into the shift register, pair counter is cleared, state goes to START. CS=0, tx_ready=0 and busy=1 are all registered at this same edge.
  - tx_valid while tx_ready=0 is ignored; it is neither queued nor latched.
- START:
  - One cycle. CS=0, lines=0.
  - The slave sees CS low on the following negedge.
  - Next state is DATA; on that edge OutLine1/OutLine0 are driven with tx_data[W-1]/tx_data[W-2].
- DATA:
  - Exactly DATA_WIDTH/2 cycles. CS=0.
  - Pair k (k=0..W/2-1) is driven as OutLine1=word[W-1-2k], OutLine0=word[W-2-2k].
  - The shift register shifts left 2 per cycle.
  - After the last pair's cycle: CS=1, lines=0, busy=0, frame_done=1 for one cycle, state goes to GAP.
- GAP:
  - CS=1 for GAP_CYCLES-1 cycles, then IDLE. IDLE counts as the final gap cycle.
  - Earliest next CS-low is GAP_CYCLES cycles after CS rises.
- Latency and throughput:
  - Accept edge to first pair on the lines: 2 posedges.
  - Accept to frame_done: DATA_WIDTH/2+1 cycles.
  - Back-to-back frame period with tx_valid held high: DATA_WIDTH/2+1+GAP_CYCLES cycles (7 for the defaults).
- Reset asserted mid-frame: at the next posedge CS=1 and lines=0, the word is discarded, no frame_done is emitted, and state is RECOVER.
- Reset held for several cycles: outputs stay at their reset values; the RECOVER count starts on the first cycle with rst=0.
- No glitch rule: CS never toggles inside a frame; lines change only on posedge.

Test Plan:
- Single frame, DATA_WIDTH=8:
  - Stimulus: after recovery (7 cycles post-reset), tx_data=8'hB4, tx_valid=1 for one cycle.
  - CS low for exactly 5 cycles (START plus 4 DATA).
  - (OutLine1,OutLine0) sequence is 10, 11, 01, 00.
  - frame_done pulses once; a connected slave's data register holds 8'hB4.
- Back-to-back: tx_valid held with 8'hA5 then 8'h3C.
  - CS high for exactly 2 cycles between the frames; frame period is 7 cycles.
  - Slave captures 8'hA5 then 8'h3C.
- Busy ignore: pulse tx_valid with 8'hFF during DATA of an 8'h0F frame.
  - 8'hFF is not sent; only 8'h0F appears; tx_ready stays 0 until IDLE.
- Reset mid-frame: assert rst for 1 cycle after pair 1 of 8'hC3.
  - Next posedge gives CS=1 and lines=00; no frame_done.
  - tx_ready=0 for 7 cycles, then a new 8'h5A is sent and received intact by the slave.
- Parameter sweep: DATA_WIDTH=16, GAP_CYCLES=3, tx_data=16'h1234.
  - 8 pairs: 00, 01, 00, 10, 00, 11, 01, 00.
  - CS high for 3 cycles between frames; slave receives 16'h1234.
- Reset values: hold rst=1 for 3 cycles.
  - CS=1, lines=00, tx_ready=0, busy=0, frame_done=0 throughout.
